// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer: funct codes, FSM states,
// and helpers used by muldiv_seq and muldiv_step.
package muldiv_pkg;

  localparam logic [5:0] MULT  = 6'h18;
  localparam logic [5:0] MULTU = 6'h19;
  localparam logic [5:0] DIV   = 6'h1A;
  localparam logic [5:0] DIVU  = 6'h1B;
  localparam logic [5:0] MTHI  = 6'h11;
  localparam logic [5:0] MTLO  = 6'h13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Iteration counter must be able to hold the value BITS.
  function automatic int cnt_w(input int bits);
    return $clog2(bits + 1);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the shared datapath: a shift-add multiply step or a
// restoring-divide step on the {acc, qr} register pair.
module muldiv_step #(
  parameter int BITS = 32
) (
  input  logic            div_mode,
  input  logic [BITS-1:0] acc,
  input  logic [BITS-1:0] qr,
  input  logic [BITS-1:0] opnd,
  output logic [BITS-1:0] acc_nx,
  output logic [BITS-1:0] qr_nx
);

  logic [BITS:0] sum;
  logic [BITS:0] sel;
  logic [BITS:0] shifted;
  logic [BITS:0] diff;

  always_comb begin
    sum     = {1'b0, acc} + {1'b0, opnd};
    sel     = qr[0] ? sum : {1'b0, acc};
    shifted = {acc, qr[BITS-1]};
    diff    = shifted - {1'b0, opnd};
    acc_nx  = sel[BITS:1];
    qr_nx   = {sel[0], qr[BITS-1:1]};
    if (div_mode) begin
      // Partial remainder never reaches the divisor, so bit BITS of diff is a clean borrow.
      if (!diff[BITS]) begin
        acc_nx = diff[BITS-1:0];
        qr_nx  = {qr[BITS-2:0], 1'b1};
      end else begin
        acc_nx = shifted[BITS-1:0];
        qr_nx  = {qr[BITS-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer with HI/LO registers and MTHI/MTLO writes.
// Optional macro MULDIV_SIGNED_EN enables signed MULT/DIV (magnitudes + sign fix-up).
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int BITS        = 32,
  parameter int OPTION_BITS = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [OPTION_BITS-1:0] funct,
  input  logic [BITS-1:0]        a,
  input  logic [BITS-1:0]        b,
  output logic                   busy,
  output logic                   done,
  output logic [BITS-1:0]        hi,
  output logic [BITS-1:0]        lo
);

  localparam int CW = cnt_w(BITS);
  localparam int W2 = 2 * BITS;

  localparam logic [OPTION_BITS-1:0] F_MULT  = OPTION_BITS'(MULT);
  localparam logic [OPTION_BITS-1:0] F_MULTU = OPTION_BITS'(MULTU);
  localparam logic [OPTION_BITS-1:0] F_DIV   = OPTION_BITS'(DIV);
  localparam logic [OPTION_BITS-1:0] F_DIVU  = OPTION_BITS'(DIVU);
  localparam logic [OPTION_BITS-1:0] F_MTHI  = OPTION_BITS'(MTHI);
  localparam logic [OPTION_BITS-1:0] F_MTLO  = OPTION_BITS'(MTLO);

  function automatic logic [BITS-1:0] cneg(input logic [BITS-1:0] x, input logic n);
    return n ? (~x + BITS'(1)) : x;
  endfunction

  function automatic logic [W2-1:0] cneg_w(input logic [W2-1:0] x, input logic n);
    return n ? (~x + W2'(1)) : x;
  endfunction

  state_t          state, state_nx;
  logic [CW-1:0]   count;
  logic            is_md, is_div_op, signed_op, accept, wr_hi, wr_lo;
  logic            sa, sb, dz;
  logic [BITS-1:0] mag_a, mag_b;

  logic            op_div_p0, neg_q_p0, neg_r_p0;
  logic [BITS-1:0] acc_p0, qr_p0, opnd_p0;
  logic [BITS-1:0] acc_nx, qr_nx;

  logic [W2-1:0]   prod_fix;
  logic [BITS-1:0] hi_fix, lo_fix;

  // Request decode and operand magnitudes (sampled only at the accept edge)
  always_comb begin
    is_md     = (funct == F_MULT) || (funct == F_MULTU) || (funct == F_DIV) || (funct == F_DIVU);
    is_div_op = (funct == F_DIV) || (funct == F_DIVU);
`ifdef MULDIV_SIGNED_EN
    signed_op = (funct == F_MULT) || (funct == F_DIV);
`else
    signed_op = 1'b0;
`endif
    sa     = signed_op & a[BITS-1];
    sb     = signed_op & b[BITS-1];
    mag_a  = cneg(a, sa);
    mag_b  = cneg(b, sb);
    dz     = (b == '0);
    accept = start && (state == IDLE) && is_md;
    wr_hi  = start && (state == IDLE) && (funct == F_MTHI);
    wr_lo  = start && (state == IDLE) && (funct == F_MTLO);
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    case (state)
      IDLE: if (accept) state_nx = RUN;
      RUN: begin
        busy = 1'b1;
        if (count == CW'(BITS - 1)) state_nx = FIX;
      end
      FIX: begin
        busy     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_nx;
      count <= (state == RUN) ? count + CW'(1) : '0;
      done  <= (state == FIX);
      if (state == FIX) begin
        hi <= hi_fix;
        lo <= lo_fix;
      end else if (wr_hi) begin
        hi <= a;
      end else if (wr_lo) begin
        lo <= a;
      end
    end
  end

  // Stage p0: operand latch at accept, then one iteration per RUN cycle
  always_ff @(posedge clk) begin
    if (accept) begin
      op_div_p0 <= is_div_op;
      // A zero divisor keeps the all-ones quotient un-negated.
      neg_q_p0  <= (sa ^ sb) & ~(is_div_op & dz);
      neg_r_p0  <= sa;
      acc_p0    <= '0;
      qr_p0     <= is_div_op ? mag_a : mag_b;
      opnd_p0   <= is_div_op ? mag_b : mag_a;
    end else if (state == RUN) begin
      acc_p0 <= acc_nx;
      qr_p0  <= qr_nx;
    end
  end

  muldiv_step #(.BITS(BITS)) u_step (
    .div_mode (op_div_p0),
    .acc      (acc_p0),
    .qr       (qr_p0),
    .opnd     (opnd_p0),
    .acc_nx   (acc_nx),
    .qr_nx    (qr_nx)
  );

  // Stage FIX: sign correction; identity when both flags are clear
  always_comb begin
    prod_fix = cneg_w({acc_p0, qr_p0}, neg_q_p0);
    if (op_div_p0) begin
      hi_fix = cneg(acc_p0, neg_r_p0);
      lo_fix = cneg(qr_p0, neg_q_p0);
    end else begin
      hi_fix = prod_fix[W2-1:BITS];
      lo_fix = prod_fix[BITS-1:0];
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq (BITS=32): directed cases, random ops vs. an
// arithmetic reference model, busy-ignore, back-to-back, MTHI/MTLO and reset behaviour.
module tb_muldiv_seq;

`ifdef MULDIV_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  localparam logic [5:0] OP_MULT  = 6'h18;
  localparam logic [5:0] OP_MULTU = 6'h19;
  localparam logic [5:0] OP_DIV   = 6'h1A;
  localparam logic [5:0] OP_DIVU  = 6'h1B;
  localparam logic [5:0] OP_MTHI  = 6'h11;
  localparam logic [5:0] OP_MTLO  = 6'h13;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  funct = 6'h0;
  logic [31:0] a = 32'h0;
  logic [31:0] b = 32'h0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  muldiv_seq #(.BITS(32), .OPTION_BITS(6)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .funct (funct),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  // Reference: returns {hi, lo} from plain arithmetic.
  function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] p;
    logic sgn;
    sgn = SGN && ((f == OP_MULT) || (f == OP_DIV));
    if ((f == OP_MULT) || (f == OP_MULTU)) begin
      if (sgn) p = longint'($signed(x)) * longint'($signed(y));
      else     p = {32'h0, x} * {32'h0, y};
      return p;
    end
    if (y == 32'h0) return {x, 32'hFFFF_FFFF};
    if (sgn) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      q  = sx / sy;
      r  = sx % sy;
      return {r[31:0], q[31:0]};
    end
    return {x % y, x / y};
  endfunction

  task automatic wait_done(output int cyc, output int bcnt, output bit got);
    cyc = 0; bcnt = 0; got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      cyc++;
      if (busy) bcnt++;
      if (done) got = 1'b1;
    end
  endtask

  task automatic do_op(input logic [5:0] f, input logic [31:0] av, input logic [31:0] bv, input string nm);
    logic [63:0] exp;
    int cyc, bcnt;
    bit got;
    exp = model(f, av, bv);
    @(negedge clk);
    start = 1'b1; funct = f; a = av; b = bv;
    @(posedge clk);
    #1 start = 1'b0; a = $urandom; b = $urandom;
    wait_done(cyc, bcnt, got);
    total++;
    if (!got || cyc != 34) $display("FAIL %s latency: got %0d (done seen %0d) expected 34", nm, cyc, got);
    else passed++;
    total++;
    if (bcnt != 33) $display("FAIL %s busy_cycles: got %0d expected 33", nm, bcnt);
    else passed++;
    total++;
    if (hi !== exp[63:32]) $display("FAIL %s hi: got %h expected %h (a=%h b=%h)", nm, hi, exp[63:32], av, bv);
    else passed++;
    total++;
    if (lo !== exp[31:0]) $display("FAIL %s lo: got %h expected %h (a=%h b=%h)", nm, lo, exp[31:0], av, bv);
    else passed++;
    @(negedge clk);
    total++;
    if (done !== 1'b0) $display("FAIL %s done_pulse: got %b expected 0", nm, done);
    else passed++;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL reset busy: got %b expected 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset done: got %b expected 0", done); else passed++;
    total++; if (hi !== 32'h0) $display("FAIL reset hi: got %h expected 0", hi); else passed++;
    total++; if (lo !== 32'h0) $display("FAIL reset lo: got %h expected 0", lo); else passed++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mthi_mtlo();
    @(negedge clk);
    start = 1'b1; funct = OP_MTHI; a = 32'h1234; b = 32'h0;
    @(posedge clk);
    #1 start = 1'b0;
    total++; if (hi !== 32'h1234) $display("FAIL mthi hi: got %h expected 1234", hi); else passed++;
    @(negedge clk);
    total++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL mthi handshake: done=%b busy=%b expected 0 0", done, busy); else passed++;
    start = 1'b1; funct = OP_MTLO; a = 32'hABCD_0001;
    @(posedge clk);
    #1 start = 1'b0;
    total++; if (lo !== 32'hABCD_0001) $display("FAIL mtlo lo: got %h expected abcd0001", lo); else passed++;
    total++; if (hi !== 32'h1234) $display("FAIL mtlo hi_kept: got %h expected 1234", hi); else passed++;
    @(negedge clk);
    total++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL mtlo handshake: done=%b busy=%b expected 0 0", done, busy); else passed++;
  endtask

  task automatic test_unknown_funct();
    logic [31:0] h0, l0;
    bit seen;
    h0 = hi; l0 = lo; seen = 1'b0;
    @(negedge clk);
    start = 1'b1; funct = 6'h20; a = 32'h5; b = 32'h3;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (busy || done) seen = 1'b1;
      @(negedge clk);
    end
    total++; if (seen) $display("FAIL unknown busy_done: got activity expected none"); else passed++;
    total++; if (hi !== h0 || lo !== l0) $display("FAIL unknown hilo: got %h/%h expected %h/%h", hi, lo, h0, l0); else passed++;
  endtask

  task automatic test_directed();
    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'h2, "multu_ffff_x2");
    do_op(OP_DIVU, 32'd100, 32'd7, "divu_100_7");
    do_op(OP_DIVU, 32'd5, 32'd0, "divu_by_zero");
    do_op(OP_DIV, 32'hFFFF_FFF9, 32'h2, "div_neg7_2");
    do_op(OP_MULT, 32'h8000_0000, 32'hFFFF_FFFF, "mult_minneg_m1");
    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_minneg_m1");
    do_op(OP_DIV, 32'hFFFF_FFFB, 32'h0, "div_neg_by_zero");
    do_op(OP_MULT, 32'hFFFF_FFFD, 32'h7, "mult_neg3_7");
  endtask

  task automatic test_random();
    logic [5:0] ops [4];
    logic [31:0] x, y;
    ops[0] = OP_MULT; ops[1] = OP_MULTU; ops[2] = OP_DIV; ops[3] = OP_DIVU;
    for (int i = 0; i < 24; i++) begin
      x = $urandom;
      y = (i % 6 == 5) ? 32'h0 : ((i % 3 == 0) ? ($urandom & 32'hFF) : $urandom);
      do_op(ops[$urandom_range(0, 3)], x, y, "random");
    end
  endtask

  task automatic test_back_to_back();
    int cyc, bcnt;
    bit got;
    @(negedge clk);
    start = 1'b1; funct = OP_DIVU; a = 32'd100; b = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0; got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      cyc++;
      if (cyc == 5) begin start = 1'b1; funct = OP_MULTU; a = 32'd3; b = 32'd3; end
      else if (cyc == 6) start = 1'b0;
      if (done) got = 1'b1;
    end
    total++; if (!got || cyc != 34) $display("FAIL b2b div_latency: got %0d expected 34", cyc); else passed++;
    total++; if (lo !== 32'd14) $display("FAIL b2b div_lo: got %h expected 0000000e", lo); else passed++;
    total++; if (hi !== 32'd2) $display("FAIL b2b div_hi: got %h expected 00000002", hi); else passed++;
    start = 1'b1; funct = OP_MULTU; a = 32'd3; b = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(cyc, bcnt, got);
    total++; if (!got || cyc != 34) $display("FAIL b2b mul_latency: got %0d expected 34", cyc); else passed++;
    total++; if (lo !== 32'd9 || hi !== 32'd0) $display("FAIL b2b mul_result: got %h/%h expected 0/9", hi, lo); else passed++;
  endtask

  task automatic test_mid_reset();
    bit seen;
    @(negedge clk);
    start = 1'b1; funct = OP_MTHI; a = 32'h55;
    @(negedge clk);
    start = 1'b1; funct = OP_MULTU; a = $urandom | 32'h1; b = $urandom | 32'h1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0) $display("FAIL midrst busy: got %b expected 0", busy); else passed++;
    total++; if (hi !== 32'h0 || lo !== 32'h0) $display("FAIL midrst hilo: got %h/%h expected 0/0", hi, lo); else passed++;
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    total++; if (seen) $display("FAIL midrst no_done: got activity after reset expected none"); else passed++;
    do_op(OP_DIVU, 32'd1000, 32'd33, "after_reset");
  endtask

  initial begin
    test_reset();
    test_mthi_mtlo();
    test_unknown_funct();
    test_directed();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
